// File: rtl/com_receiver_if.sv
// Purpose : Bundles the UART-side byte handshakes and the command/response
//           consumer signals of com_receiver into one interface.
// Ports   : slave  - com_receiver side (consumes rx bytes, drives cmd/tx)
//           master - environment side (UART model plus command consumer)
interface com_receiver_if;
    // UART receive side
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    // Command consumer side
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        frame_err;
    logic        overrun;
    // Response request side
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_busy;
    logic        resp_sent;
    // UART transmit side
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;

    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
        output clr_rx_rdy, cmd, cmd_rdy, frame_err, overrun,
               resp_busy, resp_sent, trmt, tx_data
    );

    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
        input  clr_rx_rdy, cmd, cmd_rdy, frame_err, overrun,
               resp_busy, resp_sent, trmt, tx_data
    );
endinterface

// File: rtl/com_receiver.sv
// Purpose : Remote-end command/response engine. Assembles two received bytes
//           (high first) into a 16-bit command with an inter-byte timeout,
//           and independently sends one response byte on request.
// Ports   : clk  - system clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - com_receiver_if.slave (rx handshake, cmd/cmd_rdy/
//                  clr_cmd_rdy, frame_err, overrun, send_resp/resp,
//                  resp_busy/resp_sent, trmt/tx_data/tx_done)
module com_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          rst,
    com_receiver_if.slave bus
);

    localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CMD_W   = 16;

    typedef enum logic [0:0] {
        RX_IDLE    = 1'b0,
        RX_WAIT_LB = 1'b1
    } rx_state_e;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_WAIT = 1'b1
    } tx_state_e;

    rx_state_e          rx_state_q, rx_state_d;
    tx_state_e          tx_state_q, tx_state_d;
    logic [BYTE_W-1:0]  hi_byte_q,  hi_byte_d;
    logic [TMR_W-1:0]   timer_q,    timer_d;
    logic [CMD_W-1:0]   cmd_q,      cmd_d;
    logic               cmd_rdy_q,  cmd_rdy_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q,  overrun_d;
    logic [BYTE_W-1:0]  tx_data_q,  tx_data_d;
    logic               trmt_q,     trmt_d;
    logic               resp_sent_q, resp_sent_d;

    // Last timer value before a silent WAIT_LB cycle declares a timeout
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            tx_state_q  <= TX_IDLE;
            hi_byte_q   <= '0;
            timer_q     <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            tx_state_q  <= tx_state_d;
            hi_byte_q   <= hi_byte_d;
            timer_q     <= timer_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    // RX path: byte pairing, inter-byte timeout, command ready bookkeeping
    always_comb begin
        logic complete;

        rx_state_d  = rx_state_q;
        hi_byte_d   = hi_byte_q;
        timer_d     = timer_q;
        cmd_d       = cmd_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        complete    = 1'b0;

        unique case (rx_state_q)
            RX_IDLE: begin
                if (bus.rx_rdy) begin
                    hi_byte_d  = bus.rx_data;
                    timer_d    = '0;
                    rx_state_d = RX_WAIT_LB;
                end
            end
            RX_WAIT_LB: begin
                if (bus.rx_rdy) begin
                    cmd_d      = {hi_byte_q, bus.rx_data};
                    complete   = 1'b1;
                    rx_state_d = RX_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    // Stalled frame: drop the high byte, leave cmd alone
                    frame_err_d = 1'b1;
                    rx_state_d  = RX_IDLE;
                end else if (timer_q != TMR_MAX) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        // Completion beats a same-cycle acknowledge
        cmd_rdy_d = cmd_rdy_q;
        if (bus.clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        if (complete) begin
            cmd_rdy_d = 1'b1;
            overrun_d = cmd_rdy_q;
        end
    end

    // TX path: one response byte per request, requests while busy dropped
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;

        unique case (tx_state_q)
            TX_IDLE: begin
                if (bus.send_resp) begin
                    tx_data_d  = bus.resp;
                    trmt_d     = 1'b1;
                    tx_state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (bus.tx_done) begin
                    resp_sent_d = 1'b1;
                    tx_state_d  = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Every presented byte is consumed in the cycle it is seen
    assign bus.clr_rx_rdy = bus.rx_rdy;

    assign bus.cmd       = cmd_q;
    assign bus.cmd_rdy   = cmd_rdy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.resp_busy = (tx_state_q == TX_WAIT);
    assign bus.resp_sent = resp_sent_q;
    assign bus.trmt      = trmt_q;
    assign bus.tx_data   = tx_data_q;

endmodule

// File: tb/tb_com_receiver.sv
// Purpose : Directed self-checking bench for com_receiver (TIMEOUT_CYCLES=8).
module tb_com_receiver;

    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    com_receiver_if bus ();

    com_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle rx_rdy pulse carrying byte b
    task automatic send_byte(input logic [7:0] b);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        #1;
        chk("clr_rx_rdy_hi", 32'(bus.clr_rx_rdy), 32'd1);
        tick();
        bus.rx_rdy = 1'b0;
        #1;
        chk("clr_rx_rdy_lo", 32'(bus.clr_rx_rdy), 32'd0);
    endtask

    task automatic ack_cmd();
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        chk("cmd_rdy_ack", 32'(bus.cmd_rdy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cmd"},       32'(bus.cmd),       32'h0);
        chk({tag, "_tx_data"},   32'(bus.tx_data),   32'h0);
        chk({tag, "_flags"},
            32'({bus.cmd_rdy, bus.frame_err, bus.overrun,
                 bus.resp_busy, bus.resp_sent, bus.trmt}), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.rx_rdy      = 1'b0;
        bus.rx_data     = 8'h00;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.resp        = 8'h00;
        bus.tx_done     = 1'b0;

        // Reset state
        tick(2);
        check_all_zero("reset");
        chk("reset_clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'd0);
        rst = 1'b0;
        tick();

        // Basic pair with a gap inside the timeout window
        send_byte(8'hA5);
        tick(4);
        chk("pair_mid_rdy", 32'(bus.cmd_rdy), 32'd0);
        send_byte(8'h3C);
        chk("pair_cmd",     32'(bus.cmd),     32'hA53C);
        chk("pair_rdy",     32'(bus.cmd_rdy), 32'd1);
        chk("pair_ovr",     32'(bus.overrun), 32'd0);
        ack_cmd();

        // Timeout: frame_err after exactly TMO silent cycles, once
        send_byte(8'h12);
        tick(TMO - 1);
        chk("tmo_early",    32'(bus.frame_err), 32'd0);
        tick();
        chk("tmo_pulse",    32'(bus.frame_err), 32'd1);
        chk("tmo_rdy",      32'(bus.cmd_rdy),   32'd0);
        chk("tmo_cmd_kept", 32'(bus.cmd),       32'hA53C);
        tick();
        chk("tmo_once",     32'(bus.frame_err), 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        chk("post_tmo_cmd", 32'(bus.cmd),     32'h0102);
        chk("post_tmo_rdy", 32'(bus.cmd_rdy), 32'd1);
        ack_cmd();

        // Low byte on the final counted cycle still completes
        send_byte(8'h77);
        tick(TMO - 1);
        send_byte(8'h88);
        chk("edge_cmd", 32'(bus.cmd),       32'h7788);
        chk("edge_rdy", 32'(bus.cmd_rdy),   32'd1);
        chk("edge_err", 32'(bus.frame_err), 32'd0);
        tick();
        chk("edge_err2", 32'(bus.frame_err), 32'd0);
        ack_cmd();

        // Overrun on unacknowledged completion
        send_byte(8'h11);
        send_byte(8'h11);
        chk("ovr_first", 32'(bus.overrun), 32'd0);
        send_byte(8'h22);
        send_byte(8'h22);
        chk("ovr_pulse", 32'(bus.overrun), 32'd1);
        chk("ovr_cmd",   32'(bus.cmd),     32'h2222);
        chk("ovr_rdy",   32'(bus.cmd_rdy), 32'd1);
        tick();
        chk("ovr_once",  32'(bus.overrun), 32'd0);
        chk("ovr_rdy2",  32'(bus.cmd_rdy), 32'd1);

        // Ack coinciding with completion: set wins
        send_byte(8'h33);
        bus.clr_cmd_rdy = 1'b1;
        send_byte(8'h33);
        bus.clr_cmd_rdy = 1'b0;
        chk("setwin_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("setwin_cmd", 32'(bus.cmd),     32'h3333);
        ack_cmd();

        // Response transmit, busy-drop, completion
        bus.send_resp = 1'b1;
        bus.resp      = 8'h5A;
        tick();
        bus.send_resp = 1'b0;
        chk("tx_trmt",    32'(bus.trmt),      32'd1);
        chk("tx_data",    32'(bus.tx_data),   32'h5A);
        chk("tx_busy",    32'(bus.resp_busy), 32'd1);
        tick();
        chk("tx_trmt1",   32'(bus.trmt),      32'd0);
        bus.send_resp = 1'b1;
        bus.resp      = 8'hFF;
        tick();
        bus.send_resp = 1'b0;
        chk("tx_drop_trmt", 32'(bus.trmt),    32'd0);
        chk("tx_drop_data", 32'(bus.tx_data), 32'h5A);
        chk("tx_drop_busy", 32'(bus.resp_busy), 32'd1);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("tx_sent",    32'(bus.resp_sent), 32'd1);
        chk("tx_idle",    32'(bus.resp_busy), 32'd0);
        // Re-accept in the resp_sent cycle
        bus.send_resp = 1'b1;
        bus.resp      = 8'hC3;
        tick();
        bus.send_resp = 1'b0;
        chk("tx_re_sent", 32'(bus.resp_sent), 32'd0);
        chk("tx_re_trmt", 32'(bus.trmt),      32'd1);
        chk("tx_re_data", 32'(bus.tx_data),   32'hC3);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("tx_re_done", 32'(bus.resp_sent), 32'd1);
        // tx_done while idle is ignored
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("tx_idle_done", 32'(bus.resp_sent), 32'd0);
        chk("tx_idle_busy", 32'(bus.resp_busy), 32'd0);

        // Concurrent rx frame and tx response
        bus.rx_rdy    = 1'b1;
        bus.rx_data   = 8'h4D;
        bus.send_resp = 1'b1;
        bus.resp      = 8'h96;
        tick();
        bus.rx_rdy    = 1'b0;
        bus.send_resp = 1'b0;
        chk("cc_trmt", 32'(bus.trmt),    32'd1);
        chk("cc_data", 32'(bus.tx_data), 32'h96);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h2E;
        bus.tx_done = 1'b1;
        tick();
        bus.rx_rdy  = 1'b0;
        bus.tx_done = 1'b0;
        chk("cc_cmd",  32'(bus.cmd),       32'h4D2E);
        chk("cc_rdy",  32'(bus.cmd_rdy),   32'd1);
        chk("cc_sent", 32'(bus.resp_sent), 32'd1);
        chk("cc_busy", 32'(bus.resp_busy), 32'd0);
        ack_cmd();

        // Reset mid-frame and mid-response
        send_byte(8'hAB);
        bus.send_resp = 1'b1;
        bus.resp      = 8'h3F;
        tick();
        bus.send_resp = 1'b0;
        chk("pre_rst_busy", 32'(bus.resp_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        tick();
        rst = 1'b0;
        tick();
        check_all_zero("postrst");
        send_byte(8'hBE);
        send_byte(8'hEF);
        chk("rst_cmd", 32'(bus.cmd),     32'hBEEF);
        chk("rst_rdy", 32'(bus.cmd_rdy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
